// File: rtl/accelerator_pkg.sv
// Shared accelerator types: vector opcode majors, result selector and the
// APU responder state encoding.
package accelerator_pkg;

  localparam logic [6:0] V_MAJOR_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] V_MAJOR_STORE_FP = 7'b0100111;
  localparam logic [6:0] V_MAJOR_OP_V     = 7'b1010111;

  typedef enum logic {
    APU_RESULT_SRC_VL    = 1'b0,
    APU_RESULT_SRC_VS2_0 = 1'b1
  } apu_result_src_t;

  typedef enum logic [1:0] {
    APU_IDLE,
    APU_ISSUE,
    APU_WAIT,
    APU_RESPOND
  } apu_state_e;

  typedef enum logic {
    APU_RESP_OK,
    APU_RESP_ILLEGAL
  } apu_resp_status_e;

  function automatic logic is_v_major(input logic [6:0] op);
    return (op == V_MAJOR_LOAD_FP) || (op == V_MAJOR_STORE_FP) || (op == V_MAJOR_OP_V);
  endfunction

endpackage

// File: rtl/apu_responder_if.sv
// CPU-side offload bus: request/grant plus single-cycle response.
interface apu_responder_if #(
  parameter int XLEN = 32
);
  logic            apu_req_i;
  logic [31:0]     apu_instr_i;
  logic [XLEN-1:0] apu_rs1_i;
  logic [XLEN-1:0] apu_rs2_i;
  logic            apu_gnt_o;
  logic            apu_rvalid_o;
  logic [XLEN-1:0] apu_result_o;

  modport master (
    output apu_req_i, apu_instr_i, apu_rs1_i, apu_rs2_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o
  );

  modport slave (
    input  apu_req_i, apu_instr_i, apu_rs1_i, apu_rs2_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o
  );
endinterface

// File: rtl/apu_responder.sv
// Accepts one CPU offload request at a time, forwards vector opcodes to the
// accelerator decoder, and returns a single-cycle response.
module apu_responder
  import accelerator_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            n_reset,
  apu_responder_if.slave  apu,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [31:0]     dec_instr_o,
  output logic [XLEN-1:0] dec_rs1_o,
  output logic [XLEN-1:0] dec_rs2_o,
  input  logic            done_i,
  input  apu_result_src_t result_src_i,
  input  logic [XLEN-1:0] vl_i,
  input  logic [XLEN-1:0] vs2_0_i,
  output logic            busy_o,
  output logic            illegal_o
);

  apu_state_e      state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            gnt;

  // Gated by reset so every output reads 0 while n_reset is low.
  assign gnt = apu.apu_req_i && (state_q == APU_IDLE) && n_reset;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    result_d  = result_q;
    illegal_d = 1'b0;
    unique case (state_q)
      APU_IDLE: begin
        if (gnt) begin
          instr_d = apu.apu_instr_i;
          rs1_d   = apu.apu_rs1_i;
          rs2_d   = apu.apu_rs2_i;
          if (is_v_major(apu.apu_instr_i[6:0])) begin
            state_d = APU_ISSUE;
          end else begin
            state_d   = APU_RESPOND;
            result_d  = '0;
            illegal_d = 1'b1;
          end
        end
      end
      APU_ISSUE: begin
        if (dec_ready_i) state_d = APU_WAIT;
      end
      APU_WAIT: begin
        if (done_i) begin
          result_d = (result_src_i == APU_RESULT_SRC_VL) ? vl_i : vs2_0_i;
          state_d  = APU_RESPOND;
        end
      end
      APU_RESPOND: state_d = APU_IDLE;
      default:     state_d = APU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= APU_IDLE;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign apu.apu_gnt_o    = gnt;
  assign apu.apu_rvalid_o = (state_q == APU_RESPOND);
  assign apu.apu_result_o = result_q;
  assign dec_valid_o      = (state_q == APU_ISSUE);
  assign dec_instr_o      = instr_q;
  assign dec_rs1_o        = rs1_q;
  assign dec_rs2_o        = rs2_q;
  assign busy_o           = (state_q != APU_IDLE);
  assign illegal_o        = illegal_q;

endmodule

// File: doc/apu_responder.md
APU_RESPONDER -- requirements
Module: apu_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar/result data width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port apu_req_i  input  1  CPU offload request.
REQ-005 SHALL have port apu_instr_i  input  32  instruction word, valid with apu_req_i.
REQ-006 SHALL have ports apu_rs1_i, apu_rs2_i  input  XLEN each  scalar operands, valid with apu_req_i.
REQ-007 SHALL have port apu_gnt_o  output  1  request accepted.
REQ-008 SHALL have port apu_rvalid_o  output  1  response valid, single-cycle pulse.
REQ-009 SHALL have port apu_result_o  output  XLEN  response data.
REQ-010 SHALL have ports dec_valid_o  output  1 and dec_ready_i  input  1  handshake to accelerator decoder.
REQ-011 SHALL have ports dec_instr_o  output  32 and dec_rs1_o, dec_rs2_o  output  XLEN  captured request.
REQ-012 SHALL have port done_i  input  1  accelerator finished current instruction.
REQ-013 SHALL have port result_src_i  input  apu_result_src_t  result selector, sampled with done_i.
REQ-014 SHALL have ports vl_i, vs2_0_i  input  XLEN  current VL and element 0 of vs2.
REQ-015 SHALL have ports busy_o  output  1  state not IDLE, and illegal_o  output  1  one-cycle pulse on rejected opcode.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND; one instruction outstanding at most.
REQ-017 apu_gnt_o SHALL equal apu_req_i AND state==IDLE (combinational); instr/rs1/rs2 captured on that edge.
REQ-018 On grant, opcode bits [6:0] in {V_MAJOR_LOAD_FP, V_MAJOR_STORE_FP, V_MAJOR_OP_V}: next state ISSUE.
REQ-019 On grant with any other opcode: next state RESPOND, result 0, illegal_o pulses the cycle after grant; decoder never sees it.
REQ-020 ISSUE: dec_valid_o=1, dec_* held stable until dec_valid_o&&dec_ready_i, then WAIT.
REQ-021 WAIT: on done_i, register apu_result_o = vl_i if result_src_i==APU_RESULT_SRC_VL else vs2_0_i; next RESPOND.
REQ-022 done_i outside WAIT SHALL be ignored (including the dec_ready_i handshake cycle).
REQ-023 RESPOND: apu_rvalid_o=1 for exactly one cycle, apu_result_o valid that cycle; next IDLE.
REQ-024 apu_result_o SHALL hold its value until next response; apu_gnt_o low in every state except IDLE.
REQ-025 Latency: grant cycle 0, dec_valid_o cycle 1; ready at cycle 1, done at cycle N>=2 -> rvalid cycle N+1; illegal -> rvalid cycle 1.
REQ-026 Back-to-back: request held high in RESPOND cycle SHALL be granted no earlier than the following (IDLE) cycle.

Reset
REQ-027 n_reset low SHALL immediately force state IDLE and all outputs 0 (apu_result_o, dec_* data 0), asynchronously.
REQ-028 Reset mid-operation SHALL drop the in-flight instruction with no rvalid issued after release.

Structure
REQ-029 FSM state enum and any response-status type SHALL live in accelerator_pkg; block reuses apu_result_src_t and V_MAJOR_* constants there.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 Reset: n_reset low mid-WAIT -> busy_o=0, apu_rvalid_o=0, apu_result_o=0 immediately; no response after release.
REQ-032 OP_V instr 0x00007057 (vsetvli), dec_ready_i=1 at cycle 1, done at cycle 4 with SRC_VL, vl_i=16 -> rvalid cycle 5, result 16.
REQ-033 OP_V instr, SRC_VS2_0, vs2_0_i=0xDEADBEEF, dec_ready_i delayed 3 cycles -> dec_* stable throughout, result 0xDEADBEEF.
REQ-034 Opcode 0x33 (OP) -> dec_valid_o never high, illegal_o pulse cycle 1, rvalid cycle 1 with result 0.
REQ-035 done_i pulsed during ISSUE then again in WAIT -> only WAIT pulse produces response, exactly one rvalid.
REQ-036 apu_req_i held high across two LOAD_FP instructions -> second gnt only after first rvalid, in-order results.
